// File: rtl/imm_extend_stage.sv
`default_nettype none
// ============================================================================
//  Module   : imm_extend_stage
//  Purpose  : Pipelined immediate-extension stage between instruction decode
//             and the ID/EX register. It widens an IN_W-bit immediate to OUT_W
//             bits in sign, zero, upper or branch-offset mode. A 2-entry skid
//             buffer (OR + SK) sits behind a valid/ready handshake, and a tag
//             travels with each immediate.
//  Ports    : clk, rst (async, active-high), flush (sync discard)
//             in_valid/in_ready, din[IN_W], mode[2], in_tag[TAG_W]
//             out_valid/out_ready, dout[OUT_W], out_tag[TAG_W]
//  Revision : 1.0 - initial release
// ============================================================================
module imm_extend_stage #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  din,
  input  logic [1:0]       mode,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] dout,
  output logic [TAG_W-1:0] out_tag
);

  localparam int c_PAD_W = OUT_W - IN_W;

  typedef enum logic [1:0] {
    S_EMPTY = 2'b00,
    S_ONE   = 2'b01,
    S_TWO   = 2'b10
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_in_ready;
  logic [OUT_W-1:0] r_or_data;
  logic [TAG_W-1:0] r_or_tag;
  logic [OUT_W-1:0] r_sk_data;
  logic [TAG_W-1:0] r_sk_tag;

  logic [OUT_W-1:0] w_sext;
  logic [OUT_W-1:0] w_result;
  logic             w_accept;
  logic             w_consume;
  logic             w_or_load_in;
  logic             w_or_load_sk;
  logic             w_sk_load;

  // --------------------------------------------------------------------------
  // Extension datapath: only the widened result is stored.
  // --------------------------------------------------------------------------
  assign w_sext = {{c_PAD_W{din[IN_W-1]}}, din};

  always_comb begin
    w_result = w_sext;
    case (mode)
      2'b00:   w_result = w_sext;
      2'b01:   w_result = {{c_PAD_W{1'b0}}, din};
      2'b10:   w_result = {din, {c_PAD_W{1'b0}}};
      // Branch offset: word-aligned, the two top sign bits fall off.
      default: w_result = {w_sext[OUT_W-3:0], 2'b00};
    endcase
  end

  // --------------------------------------------------------------------------
  // Handshake
  // --------------------------------------------------------------------------
  assign out_valid = (r_state != S_EMPTY);
  assign in_ready  = r_in_ready;
  assign dout      = r_or_data;
  assign out_tag   = r_or_tag;

  // A flushed cycle never captures the presented input.
  assign w_accept  = in_valid & r_in_ready & ~flush;
  assign w_consume = out_valid & out_ready;

  always_comb begin
    w_state_nxt  = r_state;
    w_or_load_in = 1'b0;
    w_or_load_sk = 1'b0;
    w_sk_load    = 1'b0;
    if (flush) begin
      w_state_nxt = S_EMPTY;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_accept) begin
            w_state_nxt  = S_ONE;
            w_or_load_in = 1'b1;
          end
        end
        S_ONE: begin
          if (w_accept && w_consume) begin
            w_or_load_in = 1'b1;
          end else if (w_accept) begin
            w_state_nxt = S_TWO;
            w_sk_load   = 1'b1;
          end else if (w_consume) begin
            w_state_nxt = S_EMPTY;
          end
        end
        S_TWO: begin
          if (w_consume) begin
            w_state_nxt  = S_ONE;
            w_or_load_sk = 1'b1;
          end
        end
        default: w_state_nxt = S_EMPTY;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // State, ready flop and storage
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_EMPTY;
      r_in_ready <= 1'b1;
      r_or_data  <= '0;
      r_or_tag   <= '0;
      r_sk_data  <= '0;
      r_sk_tag   <= '0;
    end else begin
      r_state    <= w_state_nxt;
      // in_ready comes straight from this flop; no path from out_ready.
      r_in_ready <= (w_state_nxt != S_TWO);
      if (w_or_load_in) begin
        r_or_data <= w_result;
        r_or_tag  <= in_tag;
      end else if (w_or_load_sk) begin
        r_or_data <= r_sk_data;
        r_or_tag  <= r_sk_tag;
      end
      if (w_sk_load) begin
        r_sk_data <= w_result;
        r_sk_tag  <= in_tag;
      end
    end
  end

endmodule
`default_nettype wire
